display_saida: RTL and testbench
================================

DISPLAY_SAIDA -- requirements
Module: display_saida

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clk cycles each digit stays enabled; SHALL be >= 1.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 d  in  8  value from the output register, consumed as the display source.
REQ-005 seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-006 an  out  4  digit enables, active-low, registered; an[0] units, an[1] tens, an[2] hundreds, an[3] sign.
REQ-007 bcd  out  12  last converted value {hundreds, tens, units}, 4 bits per digit.
REQ-008 negativo  out  1  high when the last converted value was negative.
REQ-009 ocupado  out  1  high while a conversion is in progress.

Function
REQ-010 d SHALL be captured into d_reg on every edge; the edge of capture is edge 0.
REQ-011 The converter FSM SHALL have states OCIOSO, DESLOCA, CARREGA.
REQ-012 In OCIOSO, if d_reg differs from the last converted value, edge 1 SHALL load the shift register, record d_reg as last converted value, and enter DESLOCA.
REQ-013 DESLOCA SHALL perform exactly 8 double-dabble iterations (add 3 to any BCD nibble >= 5, then shift left 1) on edges 2..9, then enter CARREGA.
REQ-014 CARREGA SHALL update bcd and negativo on edge 10 and return to OCIOSO; bcd SHALL change at no other time.
REQ-015 ocupado SHALL be high exactly while the FSM is in DESLOCA or CARREGA (9 cycles per conversion).
REQ-016 Changes of d during a conversion SHALL NOT affect it; on return to OCIOSO the comparison SHALL repeat and start a new conversion if needed.
REQ-017 A divider SHALL count 0..REFRESH_DIV-1; on wrap the digit index SHALL advance 0->1->2(->3 with macro)->0.
REQ-018 Exactly one an bit SHALL be low at any time outside reset.
REQ-019 seg and an SHALL be refreshed every edge from the current index and bcd, so a bcd change appears on seg no later than one edge after the update.
REQ-020 Encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, minus=0111111.
REQ-021 Hundreds SHALL be blank when 0; tens SHALL be blank when hundreds and tens are both 0; units SHALL always be shown.

Reset
REQ-022 clr high SHALL immediately force seg=7'h7F, an=4'hF, bcd=0, negativo=0, ocupado=0, FSM=OCIOSO, divider=0, index=0, d_reg=0, last converted value=0.
REQ-023 clr mid-conversion SHALL abort it; after release, d SHALL be recaptured and converted per REQ-012..014.
REQ-024 After release with d=0 no conversion SHALL start, and the display SHALL show "0".

Configuration
REQ-025 Macro SIGNED_DISPLAY_EN SHALL select signed display.
REQ-026 With SIGNED_DISPLAY_EN: d SHALL be two's complement; conversion input = magnitude (9-bit, 8'h80 -> 128); negativo = d[7]; index scans 4 digits; digit 3 shows minus when negativo, else blank.
REQ-027 Without SIGNED_DISPLAY_EN: d SHALL be unsigned 0..255; negativo tied 0; an[3] held 1; index scans 3 digits.

Verification
REQ-028 REFRESH_DIV=4, reset, d=0 -> an cycles 1110,1101,1011 each 4 clks; units seg=1000000; tens and hundreds seg=1111111.
REQ-029 d=8'd255 -> bcd=12'h255 exactly 10 edges after capture; ocupado high 9 cycles; hundreds seg=0100100.
REQ-030 d=8'd7 -> bcd=12'h007; hundreds and tens blank; units seg=1111000.
REQ-031 d=100 then d=42 three edges later -> bcd=12'h100, then 12'h042 after a second conversion; no intermediate value.
REQ-032 SIGNED_DISPLAY_EN defined: d=8'hFF -> bcd=12'h001, negativo=1, digit-3 seg=0111111; d=8'h80 -> bcd=12'h128. Undefined: d=8'hFF -> bcd=12'h255, an[3]=1 always.
REQ-033 clr pulsed at edge 5 of a conversion -> all outputs at reset values immediately; after release, d=8'd99 -> bcd=12'h099 ten edges after capture.

Source files
------------

// File: rtl/display_saida.sv
// display_saida: converts the 8-bit output register value to BCD with a
// sequential double-dabble FSM and multiplexes the digits onto an
// active-low 7-segment display.
// Optional build macro: SIGNED_DISPLAY_EN (two's complement input, sign digit on an[3]).
module display_saida #(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  d,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [11:0] bcd,
    output logic        negativo,
    output logic        ocupado
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
`ifdef SIGNED_DISPLAY_EN
    localparam int unsigned NUM_DIG = 4;
`else
    localparam int unsigned NUM_DIG = 3;
`endif
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {OCIOSO, DESLOCA, CARREGA} estado_t;

    estado_t          state, state_nxt;
    logic [7:0]       d_reg, last_val;
    logic [19:0]      sr, sr_step;
    logic [2:0]       iter;
    logic             neg_pend;
    logic [7:0]       mag;
    logic             neg_in;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic [3:0]       dig_u, dig_t, dig_h;

    function automatic logic [6:0] enc7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Conversion source: magnitude and sign of the captured value
    always_comb begin
`ifdef SIGNED_DISPLAY_EN
        mag    = d_reg[7] ? (~d_reg + 8'd1) : d_reg;
        neg_in = d_reg[7];
`else
        mag    = d_reg;
        neg_in = 1'b0;
`endif
    end

    // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left
    always_comb begin
        logic [19:0] sr_adj;
        sr_adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr_adj[8 + 4*i +: 4] >= 4'd5)
                sr_adj[8 + 4*i +: 4] = sr_adj[8 + 4*i +: 4] + 4'd3;
        end
        sr_step = {sr_adj[18:0], 1'b0};
    end

    // Converter state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= OCIOSO;
        else     state <= state_nxt;
    end

    // Converter next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            OCIOSO:  if (d_reg != last_val) state_nxt = DESLOCA;
            DESLOCA: if (iter == 3'd7)      state_nxt = CARREGA;
            CARREGA: state_nxt = OCIOSO;
            default: state_nxt = OCIOSO;
        endcase
    end

    // Converter datapath: capture, shift register, result registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d_reg    <= 8'd0;
            last_val <= 8'd0;
            sr       <= 20'd0;
            iter     <= 3'd0;
            neg_pend <= 1'b0;
            bcd      <= 12'd0;
            negativo <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            d_reg   <= d;
            ocupado <= (state_nxt != OCIOSO);
            case (state)
                OCIOSO: begin
                    if (state_nxt == DESLOCA) begin
                        sr       <= {12'd0, mag};
                        last_val <= d_reg;
                        neg_pend <= neg_in;
                        iter     <= 3'd0;
                    end
                end
                DESLOCA: begin
                    sr   <= sr_step;
                    iter <= iter + 3'd1;
                end
                CARREGA: begin
                    bcd      <= sr[19:8];
                    negativo <= neg_pend;
                end
                default: ;
            endcase
        end
    end

    // Digit decode with leading-zero blanking for the current scan index
    always_comb begin
        dig_u   = bcd[3:0];
        dig_t   = bcd[7:4];
        dig_h   = bcd[11:8];
        seg_nxt = enc7(dig_u);
        an_nxt  = 4'b1110;
        case (idx)
            2'd1: begin
                an_nxt  = 4'b1101;
                seg_nxt = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : enc7(dig_t);
            end
            2'd2: begin
                an_nxt  = 4'b1011;
                seg_nxt = (dig_h == 4'd0) ? SEG_BLANK : enc7(dig_h);
            end
`ifdef SIGNED_DISPLAY_EN
            2'd3: begin
                an_nxt  = 4'b0111;
                seg_nxt = negativo ? SEG_MINUS : SEG_BLANK;
            end
`endif
            default: begin
                an_nxt  = 4'b1110;
                seg_nxt = enc7(dig_u);
            end
        endcase
    end

    // Refresh divider, digit index and registered display drive
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            seg     <= SEG_BLANK;
            an      <= 4'hF;
        end else begin
            if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == 2'(NUM_DIG - 1)) ? 2'd0 : idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_display_saida.sv
// Directed testbench for display_saida (REFRESH_DIV = 4).
module tb_display_saida;

    localparam int unsigned RDIV = 4;
`ifdef SIGNED_DISPLAY_EN
    localparam int NDIG = 4;
`else
    localparam int NDIG = 3;
`endif
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111, SM = 7'b0111111;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  d;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [11:0] bcd;
    logic        negativo;
    logic        ocupado;

    int checks   = 0;
    int failures = 0;

    display_saida #(.REFRESH_DIV(RDIV)) dut (
        .clk(clk), .clr(clr), .d(d), .seg(seg), .an(an),
        .bcd(bcd), .negativo(negativo), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the given digit is enabled and return its segments
    task automatic wait_an(input logic [3:0] pat, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 7'bx;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (an === pat) begin
                s  = seg;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_digits(output logic [6:0] h, output logic [6:0] t,
                               output logic [6:0] u, output bit ok);
        bit okh, okt, oku;
        wait_an(4'b1011, h, okh);
        wait_an(4'b1101, t, okt);
        wait_an(4'b1110, u, oku);
        ok = okh && okt && oku;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        d   = 8'd0;
        tick();
        tick();
        checks++;
        if (seg !== SB || an !== 4'hF || bcd !== 12'd0 || negativo !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset: seg=%b an=%b bcd=%h neg=%b busy=%b required seg=%b an=1111 bcd=000 neg=0 busy=0",
                     seg, an, bcd, negativo, ocupado, SB);
        end
    endtask

    task automatic test_scan_zero();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         di;
        clr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            di = ((k - 1) / 4) % NDIG;
            case (di)
                0:       begin exp_an = 4'b1110; exp_seg = S0; end
                1:       begin exp_an = 4'b1101; exp_seg = SB; end
                2:       begin exp_an = 4'b1011; exp_seg = SB; end
                default: begin exp_an = 4'b0111; exp_seg = SB; end
            endcase
            checks++;
            if (an !== exp_an || seg !== exp_seg || ocupado !== 1'b0 || bcd !== 12'd0) begin
                failures++;
                $display("FAIL scan_zero edge %0d: an=%b seg=%b busy=%b bcd=%h required an=%b seg=%b busy=0 bcd=000",
                         k, an, seg, ocupado, bcd, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_conv_timing();
        logic [11:0] exp_bcd;
        logic [6:0]  eh, et, eu, h, t, u;
        logic        exp_busy;
        int          busy_cnt;
        bit          ok;
`ifdef SIGNED_DISPLAY_EN
        d = 8'd125; exp_bcd = 12'h125; eh = S1; et = S2; eu = S5;
`else
        d = 8'd255; exp_bcd = 12'h255; eh = S2; et = S5; eu = S5;
`endif
        busy_cnt = 0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_busy = (e >= 1 && e <= 9);
            if (ocupado === 1'b1) busy_cnt++;
            checks++;
            if (bcd !== ((e < 10) ? 12'h000 : exp_bcd) || ocupado !== exp_busy) begin
                failures++;
                $display("FAIL conv_timing edge %0d: bcd=%h busy=%b required bcd=%h busy=%b",
                         e, bcd, ocupado, (e < 10) ? 12'h000 : exp_bcd, exp_busy);
            end
        end
        checks++;
        if (busy_cnt != 9) begin
            failures++;
            $display("FAIL conv_busy_cycles: got %0d required 9", busy_cnt);
        end
        read_digits(h, t, u, ok);
        checks++;
        if (!ok || h !== eh || t !== et || u !== eu) begin
            failures++;
            $display("FAIL conv_digits: h=%b t=%b u=%b ok=%0d required h=%b t=%b u=%b",
                     h, t, u, ok, eh, et, eu);
        end
    endtask

    task automatic test_small();
        logic [6:0] h, t, u;
        bit         ok;
        d = 8'd7;
        for (int e = 0; e <= 10; e++) tick();
        checks++;
        if (bcd !== 12'h007 || negativo !== 1'b0) begin
            failures++;
            $display("FAIL small_bcd: bcd=%h neg=%b required bcd=007 neg=0", bcd, negativo);
        end
        read_digits(h, t, u, ok);
        checks++;
        if (!ok || h !== SB || t !== SB || u !== S7) begin
            failures++;
            $display("FAIL small_digits: h=%b t=%b u=%b ok=%0d required h=%b t=%b u=%b",
                     h, t, u, ok, SB, SB, S7);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_bcd;
        logic        exp_busy;
        d = 8'd100;
        for (int e = 0; e <= 22; e++) begin
            tick();
            if (e == 2) d = 8'd42;
            exp_bcd  = (e < 10) ? 12'h007 : ((e < 20) ? 12'h100 : 12'h042);
            exp_busy = (e >= 1 && e <= 9) || (e >= 11 && e <= 19);
            checks++;
            if (bcd !== exp_bcd || ocupado !== exp_busy) begin
                failures++;
                $display("FAIL back_to_back edge %0d: bcd=%h busy=%b required bcd=%h busy=%b",
                         e, bcd, ocupado, exp_bcd, exp_busy);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] h, t, u;
        bit         ok;
        d = 8'd105;
        for (int e = 0; e <= 10; e++) tick();
        checks++;
        if (bcd !== 12'h105) begin
            failures++;
            $display("FAIL blank_bcd: bcd=%h required 105", bcd);
        end
        read_digits(h, t, u, ok);
        checks++;
        if (!ok || h !== S1 || t !== S0 || u !== S5) begin
            failures++;
            $display("FAIL blank_digits: h=%b t=%b u=%b ok=%0d required h=%b t=%b u=%b",
                     h, t, u, ok, S1, S0, S5);
        end
    endtask

    task automatic test_sign();
        logic [11:0] exp_ff;
        logic        exp_neg;
        logic [6:0]  s;
        bit          ok;
        int          an3_low;
`ifdef SIGNED_DISPLAY_EN
        exp_ff = 12'h001; exp_neg = 1'b1;
`else
        exp_ff = 12'h255; exp_neg = 1'b0;
`endif
        d = 8'hFF;
        for (int e = 0; e <= 10; e++) tick();
        checks++;
        if (bcd !== exp_ff || negativo !== exp_neg) begin
            failures++;
            $display("FAIL sign_ff: bcd=%h neg=%b required bcd=%h neg=%b", bcd, negativo, exp_ff, exp_neg);
        end
`ifdef SIGNED_DISPLAY_EN
        wait_an(4'b0111, s, ok);
        checks++;
        if (!ok || s !== SM) begin
            failures++;
            $display("FAIL sign_minus: seg=%b ok=%0d required %b", s, ok, SM);
        end
`else
        an3_low = 0;
        s  = SB;
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (an[3] !== 1'b1) an3_low++;
        end
        checks++;
        if (an3_low != 0 || !ok || s !== SB) begin
            failures++;
            $display("FAIL sign_an3: cycles with an[3] low=%0d required 0", an3_low);
        end
`endif
        d = 8'h80;
        for (int e = 0; e <= 10; e++) tick();
        checks++;
        if (bcd !== 12'h128 || negativo !== exp_neg) begin
            failures++;
            $display("FAIL sign_80: bcd=%h neg=%b required bcd=128 neg=%b", bcd, negativo, exp_neg);
        end
    endtask

    task automatic test_clr_mid();
        logic [6:0] h, t, u;
        logic       exp_busy;
        bit         ok;
        d = 8'd200;
        for (int e = 0; e <= 4; e++) tick();
        clr = 1'b1;
        #1;
        checks++;
        if (seg !== SB || an !== 4'hF || bcd !== 12'd0 || negativo !== 1'b0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL clr_async: seg=%b an=%b bcd=%h neg=%b busy=%b required seg=%b an=1111 bcd=000 neg=0 busy=0",
                     seg, an, bcd, negativo, ocupado, SB);
        end
        tick();
        clr = 1'b0;
        d   = 8'd99;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_busy = (e >= 1 && e <= 9);
            checks++;
            if (bcd !== ((e < 10) ? 12'h000 : 12'h099) || ocupado !== exp_busy) begin
                failures++;
                $display("FAIL clr_reconv edge %0d: bcd=%h busy=%b required bcd=%h busy=%b",
                         e, bcd, ocupado, (e < 10) ? 12'h000 : 12'h099, exp_busy);
            end
        end
        read_digits(h, t, u, ok);
        checks++;
        if (!ok || h !== SB || t !== S9 || u !== S9) begin
            failures++;
            $display("FAIL clr_digits: h=%b t=%b u=%b ok=%0d required h=%b t=%b u=%b",
                     h, t, u, ok, SB, S9, S9);
        end
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_conv_timing();
        test_small();
        test_back_to_back();
        test_blanking();
        test_sign();
        test_clr_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
